// File: rtl/dffe_bank_write_arbiter.sv
// dffe_bank_write_arbiter
//
// Round-robin write arbiter and sequencer for a bank of DEPTH enable-flops.
// NUM_REQ requesters share the bank's single write path. A write accepted on
// one edge is issued on the next cycle: a one-hot enable on reg_en and the
// data on reg_d. Holding clr high turns every issue cycle into a bank-clear
// cycle (reg_en all-ones, reg_d zero). Addresses at or above DEPTH are not
// written and are reported on err/err_id instead.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [NUM_REQ]        per-requester write request
//   req_addr   [NUM_REQ*AW]     packed; requester i at [i*AW +: AW]
//   req_data   [NUM_REQ*WIDTH]  packed; requester i at [i*WIDTH +: WIDTH]
//   req_ready  [NUM_REQ]        combinational grant; at most one bit high
//   clr        synchronous bank-clear request, level-sampled
//   reg_en     [DEPTH]          registered per-register enable strobe
//   reg_d      [WIDTH]          registered common write data
//   grant_id   [IDW]            requester whose write is on reg_en/reg_d
//   err        registered one-cycle pulse: out-of-range address accepted
//   err_id     [IDW]            requester that caused err

module dffe_bank_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     clr,
  output logic [DEPTH-1:0]         reg_en,
  output logic [WIDTH-1:0]         reg_d,
  output logic [IDW-1:0]           grant_id,
  output logic                     err,
  output logic [IDW-1:0]           err_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_nxt;
  logic [IDW-1:0]     win_id;
  logic               win_found;
  logic               xfer;
  logic [AW-1:0]      sel_addr;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_oor;
  logic [DEPTH-1:0]   sel_onehot;

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  // clr and the CLEAR state both block transfers; reset forces ready low
  // so nothing is accepted while the pipeline is being flushed.
  assign xfer = rst_n && (state == IDLE) && !clr && win_found;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign ptr_nxt = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

  // Only req_valid/ptr/clr/state reach req_ready; the address and data
  // mux below feeds the issue registers only.
  assign sel_addr   = req_addr[win_id*AW +: AW];
  assign sel_data   = req_data[win_id*WIDTH +: WIDTH];
  assign sel_oor    = int'(sel_addr) >= DEPTH;
  assign sel_onehot = DEPTH'(1) << sel_addr;

  // Clear stays in force for as long as clr is sampled high; one dead
  // cycle in CLEAR follows before arbitration resumes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = clr ? CLEAR : IDLE;
      CLEAR:   state_nxt = clr ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        ptr <= ptr_nxt;
      end
    end
  end

  // ---- issue stage: one cycle after the transfer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_en   <= '0;
      reg_d    <= '0;
      grant_id <= '0;
      err      <= 1'b0;
      err_id   <= '0;
    end else begin
      reg_en <= '0;
      err    <= 1'b0;
      if (state_nxt == CLEAR) begin
        reg_en <= '1;
        reg_d  <= '0;
      end else if (xfer) begin
        reg_d <= sel_data;
        if (sel_oor) begin
          err    <= 1'b1;
          err_id <= win_id;
        end else begin
          reg_en   <= sel_onehot;
          grant_id <= win_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_dffe_bank_write_arbiter.sv
// Directed bench for dffe_bank_write_arbiter: a DEPTH=8 instance feeding a
// modelled bank of eight DFFEs, and a DEPTH=6 instance for out-of-range
// addresses. Inputs change just after the rising edge; outputs are sampled
// #1 later, well away from the next edge.

module tb_dffe_bank_write_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  a_valid;
  logic [11:0] a_addr;
  logic [31:0] a_data;
  logic [3:0]  a_ready;
  logic        a_clr;
  logic [7:0]  a_reg_en;
  logic [7:0]  a_reg_d;
  logic [1:0]  a_grant_id;
  logic        a_err;
  logic [1:0]  a_err_id;

  logic [3:0]  b_valid;
  logic [11:0] b_addr;
  logic [31:0] b_data;
  logic [3:0]  b_ready;
  logic        b_clr;
  logic [5:0]  b_reg_en;
  logic [7:0]  b_reg_d;
  logic [1:0]  b_grant_id;
  logic        b_err;
  logic [1:0]  b_err_id;

  logic [7:0]  q [8];

  int checks;
  int errors;
  int gcnt [4];

  dffe_bank_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_valid), .req_addr(a_addr), .req_data(a_data),
    .req_ready(a_ready), .clr(a_clr),
    .reg_en(a_reg_en), .reg_d(a_reg_d), .grant_id(a_grant_id),
    .err(a_err), .err_id(a_err_id)
  );

  dffe_bank_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(6)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_valid), .req_addr(b_addr), .req_data(b_data),
    .req_ready(b_ready), .clr(b_clr),
    .reg_en(b_reg_en), .reg_d(b_reg_d), .grant_id(b_grant_id),
    .err(b_err), .err_id(b_err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank of DFFEs driven by instance A.
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (a_reg_en[k]) q[k] <= a_reg_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_a(input int i, input logic [2:0] ad, input logic [7:0] d);
    a_addr[i*3 +: 3] = ad;
    a_data[i*8 +: 8] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    a_valid = '0; a_addr = '0; a_data = '0; a_clr = 1'b0;
    b_valid = '0; b_addr = '0; b_data = '0; b_clr = 1'b0;
    for (int k = 0; k < 4; k++) gcnt[k] = 0;

    // Reset state, with requests present to show ready is held low.
    a_valid = 4'b1111;
    step();
    step();
    chk("rst_reg_en",   32'(a_reg_en),   32'h0);
    chk("rst_reg_d",    32'(a_reg_d),    32'h0);
    chk("rst_grant_id", 32'(a_grant_id), 32'h0);
    chk("rst_err",      32'(a_err),      32'h0);
    chk("rst_err_id",   32'(a_err_id),   32'h0);
    chk("rst_ready",    32'(a_ready),    32'h0);
    a_valid = '0;
    rst_n   = 1'b1;
    #1;

    // Single write: req 2, addr 5, data A5.
    a_valid = 4'b0100;
    set_a(2, 3'd5, 8'hA5);
    #1;
    chk("single_ready", 32'(a_ready), 32'h4);
    step();
    a_valid = '0;
    chk("single_en",  32'(a_reg_en),   32'h20);
    chk("single_d",   32'(a_reg_d),    32'hA5);
    chk("single_gid", 32'(a_grant_id), 32'h2);
    step();
    chk("single_en_off", 32'(a_reg_en), 32'h0);

    // Fairness from reset: all four held valid for 8 cycles.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_a(i, 3'(i), 8'(8'h30 + i));
    a_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("fair_ready", 32'(a_ready), 32'(4'b0001 << (c % 4)));
      step();
      chk("fair_gid", 32'(a_grant_id), 32'(c % 4));
      chk("fair_en",  32'(a_reg_en),   32'(8'h01 << (c % 4)));
      gcnt[a_grant_id]++;
    end
    a_valid = '0;
    for (int k = 0; k < 4; k++) chk("fair_count", 32'(gcnt[k]), 32'd2);

    // Clear priority. Move ptr to 1 first with a write from req 0.
    step();
    a_valid = 4'b0001;
    set_a(0, 3'd6, 8'h66);
    step();
    a_valid = 4'b1010;
    set_a(1, 3'd3, 8'h11);
    set_a(3, 3'd7, 8'h33);
    a_clr = 1'b1;
    #1;
    chk("clr_ready0", 32'(a_ready), 32'h0);
    step();
    chk("clr_en0", 32'(a_reg_en), 32'hFF);
    chk("clr_d0",  32'(a_reg_d),  32'h0);
    chk("clr_ready1", 32'(a_ready), 32'h0);
    step();
    chk("clr_en1", 32'(a_reg_en), 32'hFF);
    chk("clr_d1",  32'(a_reg_d),  32'h0);
    a_clr = 1'b0;
    #1;
    chk("clr_dead_ready", 32'(a_ready), 32'h0);
    step();
    chk("clr_en_off", 32'(a_reg_en), 32'h0);
    chk("clr_next_ready", 32'(a_ready), 32'h2);
    step();
    a_valid = '0;
    chk("clr_next_gid", 32'(a_grant_id), 32'h1);
    chk("clr_next_en",  32'(a_reg_en),   32'h08);

    // Reset mid-operation while reg_en = 0x04 (ptr is 2 -> 3 beforehand).
    step();
    a_valid = 4'b0100;
    set_a(2, 3'd2, 8'h22);
    step();
    a_valid = '0;
    chk("midrst_en_pre", 32'(a_reg_en), 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_en_low", 32'(a_reg_en), 32'h0);
    step();
    rst_n = 1'b1;
    a_valid = 4'b1111;
    #1;
    chk("midrst_ready", 32'(a_ready), 32'h1);
    step();
    a_valid = '0;
    chk("midrst_gid", 32'(a_grant_id), 32'h0);

    // Integration: addr 0..7, data 0x10..0x17, alternating req 0 and req 1.
    step();
    for (int a = 0; a < 8; a++) begin
      a_valid = 4'(1 << (a % 2));
      set_a(a % 2, 3'(a), 8'(8'h10 + a));
      step();
    end
    a_valid = '0;
    step();
    step();
    for (int a = 0; a < 8; a++) chk("bank_q", 32'(q[a]), 32'(8'h10 + a));
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    step();
    step();
    for (int a = 0; a < 8; a++) chk("bank_q_clr", 32'(q[a]), 32'h0);

    // DEPTH=6 instance: in-range then out-of-range.
    b_valid = 4'b0010;
    b_addr[3 +: 3] = 3'd5;
    b_data[8 +: 8] = 8'h55;
    step();
    b_valid = '0;
    chk("b_in_en",  32'(b_reg_en), 32'h20);
    chk("b_in_err", 32'(b_err),    32'h0);
    b_valid = 4'b1000;
    b_addr[9 +: 3] = 3'd7;
    b_data[24 +: 8] = 8'h5C;
    #1;
    chk("oor_ready", 32'(b_ready), 32'h8);
    step();
    b_valid = '0;
    chk("oor_en",     32'(b_reg_en), 32'h0);
    chk("oor_err",    32'(b_err),    32'h1);
    chk("oor_err_id", 32'(b_err_id), 32'h3);
    chk("oor_d",      32'(b_reg_d),  32'h5C);
    step();
    chk("oor_err_off", 32'(b_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
